// File: rtl/ir_sched_if.sv
// Bus/switch side of the IR packet scheduler: requester inputs and the
// transmitter-facing COMMAND/SEND_PACKET/BUSY/PACKET_COUNT outputs.
interface ir_sched_if;
  logic       enable;
  logic       sw_mode;
  logic [3:0] sw_cmd;
  logic       bus_cmd_we;
  logic [3:0] bus_cmd_data;
  logic [3:0] command;
  logic       send_packet;
  logic       busy;
  logic [7:0] packet_count;

  modport master (
    output enable, sw_mode, sw_cmd, bus_cmd_we, bus_cmd_data,
    input  command, send_packet, busy, packet_count
  );

  modport slave (
    input  enable, sw_mode, sw_cmd, bus_cmd_we, bus_cmd_data,
    output command, send_packet, busy, packet_count
  );
endinterface

// File: rtl/ir_packet_scheduler.sv
// IR packet scheduler: picks the drive command from the bus register or the
// switches, launches packets periodically or early on a new request, and
// freezes COMMAND for the duration of each packet.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | disabled; counter and pending flag cleared, outputs held
// ST_LAUNCH | one cycle: SEND_PACKET high, COMMAND just loaded
// ST_HOLD   | packet in flight, BUSY high, COMMAND frozen
// ST_WAIT   | waiting for period expiry, pending write or switch change
module ir_packet_scheduler #(
  parameter int unsigned PERIOD_CYCLES = 10_000_000,
  parameter int unsigned PACKET_CYCLES = 1_600_000,
  parameter int unsigned COUNTER_WIDTH = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  ir_sched_if.slave   sif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_HOLD   = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = COUNTER_WIDTH'(PERIOD_CYCLES - 1);
  // CNT reads 0 on the first HOLD cycle, so leaving at PACKET_CYCLES-2 gives
  // PACKET_CYCLES-1 busy cycles and an earliest relaunch PACKET_CYCLES+1
  // cycles after the previous one.
  localparam logic [COUNTER_WIDTH-1:0] CNT_HOLD_END = COUNTER_WIDTH'(PACKET_CYCLES - 2);

  state_t                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic                     pending_q, pending_d;
  logic [3:0]               bus_reg_q, bus_reg_d;
  logic [3:0]               command_q, command_d;
  logic                     send_packet_q, send_packet_d;
  logic                     busy_q, busy_d;
  logic [7:0]               packet_count_q, packet_count_d;
  logic [3:0]               sel_cmd;
  logic                     launch;

  // Next-state, counter, pending flag and registered-output computation.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pending_d      = pending_q;
    bus_reg_d      = bus_reg_q;
    command_d      = command_q;
    send_packet_d  = 1'b0;
    busy_d         = 1'b0;
    packet_count_d = packet_count_q;
    sel_cmd        = sif.sw_mode ? sif.sw_cmd : bus_reg_q;
    launch         = 1'b0;

    if (sif.bus_cmd_we) begin
      bus_reg_d = sif.bus_cmd_data;
    end

    case (state_q)
      ST_IDLE:   state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_HOLD;
      ST_HOLD:   if (cnt_q == CNT_HOLD_END) state_d = ST_WAIT;
      ST_WAIT: begin
        if ((cnt_q == CNT_MAX) || pending_q ||
            (sif.sw_mode && (sif.sw_cmd != command_q))) begin
          state_d = ST_LAUNCH;
        end
      end
      default:   state_d = ST_IDLE;
    endcase

    if (!sif.enable) begin
      state_d = ST_IDLE;
    end

    launch = (state_d == ST_LAUNCH);

    if (!sif.enable || (state_q == ST_IDLE) || (state_q == ST_LAUNCH)) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + COUNTER_WIDTH'(1);
    end

    // A write landing on the launch edge survives the clear (set wins).
    pending_d = (pending_q && !launch) || (sif.bus_cmd_we && !sif.sw_mode);
    if (!sif.enable) begin
      pending_d = 1'b0;
    end

    // COMMAND loads on the edge entering LAUNCH, from pre-edge register values.
    if (launch) begin
      command_d      = sel_cmd;
      send_packet_d  = 1'b1;
      packet_count_d = packet_count_q + 8'd1;
    end
    busy_d = (state_d == ST_HOLD);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      pending_q      <= 1'b0;
      bus_reg_q      <= 4'b0000;
      command_q      <= 4'b0000;
      send_packet_q  <= 1'b0;
      busy_q         <= 1'b0;
      packet_count_q <= 8'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      bus_reg_q      <= bus_reg_d;
      command_q      <= command_d;
      send_packet_q  <= send_packet_d;
      busy_q         <= busy_d;
      packet_count_q <= packet_count_d;
    end
  end

  assign sif.command      = command_q;
  assign sif.send_packet  = send_packet_q;
  assign sif.busy         = busy_q;
  assign sif.packet_count = packet_count_q;

endmodule
